// File: rtl/chip8_keypad_if.sv
`default_nettype none
// ============================================================================
// Module      : chip8_keypad_if
// Description : Key-state bus from the keypad scanner (producer) to the
//               CHIP-8 CPU (consumer): debounced key bitmap plus the
//               optional new-press event and its hex code.
// Revision    : 1.0 - initial release
// ============================================================================
interface chip8_keypad_if;
    logic [15:0] keys;       // bit n = hex key n currently held (debounced)
    logic        key_event;  // one-cycle pulse on a new key press
    logic [3:0]  key_code;   // hex code of the most recent new press

    modport master (
        output keys,
        output key_event,
        output key_code
    );

    modport slave (
        input  keys,
        input  key_event,
        input  key_code
    );
endinterface
`default_nettype wire

// File: rtl/chip8_keypad.sv
`default_nettype none
// ============================================================================
// Module      : chip8_keypad
// Description : 4x4 hex keypad matrix scanner and per-key debouncer.
//               Columns are driven active-low one at a time, rows are
//               sampled through a two-flop synchroniser at the end of each
//               column slot, and every key is debounced independently.
//               Optional macro KEYPAD_EVENT_EN adds a new-press event pulse
//               and the hex code of the pressed key; without it those bus
//               signals are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_keypad #(
    parameter int SCAN_DIV     = 50_000,  // clk cycles per column slot
    parameter int DEBOUNCE_CNT = 20       // disagreeing samples needed to flip a key
) (
    input  logic                  clk,
    input  logic                  reset,    // asynchronous assert, active low
    input  logic [3:0]            row_in,   // active-low rows, asynchronous to clk
    output logic [3:0]            col_out,  // active-low columns, exactly one low
    chip8_keypad_if.master        kbus
);

    localparam int c_SLOT_W = $clog2(SCAN_DIV);
    localparam int c_DB_W   = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);

    // Hex code of the key at matrix position (row*4 + col), 4 bits per entry,
    // position 0 in the least significant nibble.
    //   r0: 1 2 3 C   r1: 4 5 6 D   r2: 7 8 9 E   r3: A 0 B F
    localparam logic [63:0] c_KEY_MAP = 64'hFB0A_E987_D654_C321;

    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_sync;
    logic [c_SLOT_W-1:0] r_slot_cnt;
    logic [1:0]          r_col_idx;
    logic [1:0]          w_col_nxt;
    logic [3:0]          r_col_out;
    logic [15:0]         r_keys;
    logic [15:0]         w_keys_nxt;
    logic [c_DB_W-1:0]   r_db_cnt   [16];
    logic [c_DB_W-1:0]   w_db_nxt   [16];
    logic                w_sample;
    logic [3:0]          w_raw;
    logic [3:0]          w_key_idx;

    // The last cycle of every column slot is the sample cycle.
    assign w_sample  = (r_slot_cnt == c_SLOT_LAST);
    assign w_raw     = ~r_row_sync;
    assign w_col_nxt = r_col_idx + 2'd1;
    assign col_out   = r_col_out;

    // Two-flop synchroniser for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    // Column scanner: advance to the next column after each sample cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_cnt <= '0;
            r_col_idx  <= 2'd0;
            r_col_out  <= 4'b1110;
        end else if (w_sample) begin
            r_slot_cnt <= '0;
            r_col_idx  <= w_col_nxt;
            r_col_out  <= ~(4'b0001 << w_col_nxt);
        end else begin
            r_slot_cnt <= r_slot_cnt + c_SLOT_W'(1);
        end
    end

    // Debounce next state: only the four keys of the active column are
    // updated, and only in the sample cycle.
    always_comb begin
        w_keys_nxt = r_keys;
        w_key_idx  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            w_db_nxt[k] = r_db_cnt[k];
        end
        if (w_sample) begin
            for (int r = 0; r < 4; r++) begin
                w_key_idx = c_KEY_MAP[(r * 4 + int'(r_col_idx)) * 4 +: 4];
                if (w_raw[r] == r_keys[w_key_idx]) begin
                    w_db_nxt[w_key_idx] = '0;
                end else if (r_db_cnt[w_key_idx] == c_DB_LAST) begin
                    w_keys_nxt[w_key_idx] = ~r_keys[w_key_idx];
                    w_db_nxt[w_key_idx]   = '0;
                end else begin
                    w_db_nxt[w_key_idx] = r_db_cnt[w_key_idx] + c_DB_ONE;
                end
            end
        end
    end

    // Debounced key state and per-key disagreement counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keys <= 16'h0000;
            for (int k = 0; k < 16; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_keys <= w_keys_nxt;
            for (int k = 0; k < 16; k++) begin
                r_db_cnt[k] <= w_db_nxt[k];
            end
        end
    end

    assign kbus.keys = r_keys;

`ifdef KEYPAD_EVENT_EN
    logic [15:0] r_keys_d;
    logic [15:0] w_rise;
    logic [3:0]  w_rise_code;
    logic        r_key_event;
    logic [3:0]  r_key_code;

    assign w_rise = r_keys & ~r_keys_d;

    // Lowest-numbered key among those that rose this cycle.
    always_comb begin
        w_rise_code = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_rise[k]) begin
                w_rise_code = 4'(k);
            end
        end
    end

    // Press event is raised the cycle after a key bit rises; the code is
    // held until the next press. Releases are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keys_d    <= 16'h0000;
            r_key_event <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_keys_d    <= r_keys;
            r_key_event <= |w_rise;
            if (|w_rise) begin
                r_key_code <= w_rise_code;
            end
        end
    end

    assign kbus.key_event = r_key_event;
    assign kbus.key_code  = r_key_code;
`else
    assign kbus.key_event = 1'b0;
    assign kbus.key_code  = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chip8_keypad.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_keypad
// Description : Self-checking bench for chip8_keypad with SCAN_DIV=4 and
//               DEBOUNCE_CNT=3. An ideal key matrix is modelled from the
//               set of pressed keys; expected key states come from the
//               press/release history and the debounce latency bounds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_keypad;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int SCAN         = 4 * SCAN_DIV;
    localparam int T_EARLY      = (DEBOUNCE_CNT - 1) * SCAN;   // key cannot have flipped yet
    localparam int T_LATE       = DEBOUNCE_CNT * SCAN + 3;     // key must have flipped
`ifdef KEYPAD_EVENT_EN
    localparam int EV_ON = 1;
`else
    localparam int EV_ON = 0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int ev_count = 0;
    int ev_bad = 0;

    chip8_keypad_if kbus ();

    chip8_keypad #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .row_in  (row_in),
        .col_out (col_out),
        .kbus    (kbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int key_at(int r, int c);
        int t [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};
        return t[r * 4 + c];
    endfunction

    function automatic logic [3:0] lowest_bit(logic [15:0] v);
        for (int k = 0; k < 16; k++) begin
            if (v[k]) return 4'(k);
        end
        return 4'd0;
    endfunction

    // Ideal matrix: a row is pulled low when a held key sits on the driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_out[c] && pressed[key_at(r, c)]) row_in[r] = 1'b0;
            end
        end
    end

    // Event monitor: a pulse must follow every cycle in which some key rose,
    // carrying the lowest rising key code; nothing otherwise.
    logic [15:0] kp1 = 16'h0, kp2 = 16'h0;
    always @(negedge clk) begin
        if (kbus.key_event === 1'b1) ev_count++;
`ifdef KEYPAD_EVENT_EN
        if (reset === 1'b1) begin
            if (kbus.key_event !== (|(kp1 & ~kp2))) ev_bad++;
            if ((|(kp1 & ~kp2)) && kbus.key_code !== lowest_bit(kp1 & ~kp2)) ev_bad++;
        end
`else
        if (kbus.key_event !== 1'b0 || kbus.key_code !== 4'd0) ev_bad++;
`endif
        kp2 = kp1;
        kp1 = kbus.keys;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] model;
    logic [15:0] newp;
    int          base;
    int          waited;

    initial begin
        pressed = 16'h0000;
        model   = 16'h0000;
        reset   = 1'b1;
        #1 reset = 1'b0;

        // Reset held: columns parked on column 0, no keys.
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("rst_col", 32'(col_out), 32'(4'b1110));
            check("rst_keys", 32'(kbus.keys), 32'h0);
        end
        reset = 1'b1;

        // Idle scan: each column low for SCAN_DIV cycles, in order, wrapping.
        for (int i = 0; i < 2 * SCAN; i++) begin
            check("scan_col", 32'(col_out), 32'(4'hF & ~(4'b0001 << ((i / SCAN_DIV) % 4))));
            cyc(1);
        end
        check("idle_keys", 32'(kbus.keys), 32'h0);

        // Key 5 press and release, with latency window.
        cyc($urandom_range(0, SCAN - 1));
        pressed = 16'h0020;
        cyc(T_EARLY);
        check("k5_press_early", 32'(kbus.keys), 32'h0);
        cyc(T_LATE - T_EARLY);
        check("k5_press", 32'(kbus.keys), 32'h0020);
        pressed = 16'h0000;
        cyc(T_EARLY);
        check("k5_rel_early", 32'(kbus.keys), 32'h0020);
        cyc(T_LATE - T_EARLY);
        check("k5_rel", 32'(kbus.keys), 32'h0);

        // Bounce: pressed for one scan, released one, pressed one -> no change.
        cyc($urandom_range(0, SCAN - 1));
        pressed = 16'h0020;
        cyc(SCAN);
        check("bounce1", 32'(kbus.keys), 32'h0);
        pressed = 16'h0000;
        cyc(SCAN);
        check("bounce2", 32'(kbus.keys), 32'h0);
        pressed = 16'h0020;
        cyc(SCAN);
        check("bounce3", 32'(kbus.keys), 32'h0);
        pressed = 16'h0000;
        cyc(T_LATE);
        check("bounce_end", 32'(kbus.keys), 32'h0);

        // Press events: two keys in one column, then a third key.
        base = ev_count;
        pressed = 16'h0104;
        cyc(T_LATE + 2);
        check("ev_keys1", 32'(kbus.keys), 32'h0104);
        check("ev_count1", 32'(ev_count - base), 32'(EV_ON));
        check("ev_code1", 32'(kbus.key_code), EV_ON ? 32'h2 : 32'h0);
        pressed = 16'h8104;
        cyc(T_LATE + 2);
        check("ev_keys2", 32'(kbus.keys), 32'h8104);
        check("ev_count2", 32'(ev_count - base), 32'(2 * EV_ON));
        check("ev_code2", 32'(kbus.key_code), EV_ON ? 32'hF : 32'h0);
        pressed = 16'h0000;
        cyc(T_LATE + 2);
        check("ev_rel_keys", 32'(kbus.keys), 32'h0);
        check("ev_rel_count", 32'(ev_count - base), 32'(2 * EV_ON));
        check("ev_rel_code", 32'(kbus.key_code), EV_ON ? 32'hF : 32'h0);

        // Randomised key patterns held long enough to settle.
        model = 16'h0000;
        for (int it = 0; it < 8; it++) begin
            newp = 16'($urandom & $urandom);
            cyc($urandom_range(0, SCAN - 1));
            pressed = newp;
            cyc(T_EARLY);
            check("rnd_early", 32'(kbus.keys), 32'(model));
            cyc(T_LATE - T_EARLY);
            check("rnd_late", 32'(kbus.keys), 32'(newp));
            model = newp;
        end
        pressed = 16'h0000;
        cyc(T_LATE);
        check("rnd_clear", 32'(kbus.keys), 32'h0);

        // Reset in the middle of a held press discards all progress.
        pressed = 16'h0001;
        waited = 0;
        while (kbus.keys !== 16'h0001 && waited < T_LATE + 10) begin
            cyc(1);
            waited++;
        end
        check("k0_set", 32'(kbus.keys), 32'h0001);
        cyc($urandom_range(1, 10));
        #2 reset = 1'b0;
        #1;
        check("midrst_keys", 32'(kbus.keys), 32'h0);
        check("midrst_col", 32'(col_out), 32'(4'b1110));
        cyc(3);
        reset = 1'b1;
        cyc(T_EARLY);
        check("k0_after_rst_early", 32'(kbus.keys), 32'h0);
        cyc(T_LATE - T_EARLY);
        check("k0_after_rst", 32'(kbus.keys), 32'h0001);
        pressed = 16'h0000;
        cyc(T_LATE + 2);
        check("k0_rel", 32'(kbus.keys), 32'h0);

        check("event_monitor", 32'(ev_bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
